relu_backprop: RTL and testbench
================================

Name: relu_backprop

Overview:
- Backward-pass companion to the forward ReLU stage in the TTPU datapath.
- During the forward pass it captures a per-element "strictly positive" mask of each pre-activation vector into a mask FIFO.
- During the backward pass it pops masks in the same order and zeroes the matching gradient elements.
- The gated gradient vector is presented through a registered valid/ready output stage to the upstream gradient consumer.

Parameters:
- DATA_WIDTH, 16: bit width of each signed (two's complement) element.
- LENGTH, 16: number of elements per vector.
- DEPTH, 4: mask FIFO entries, LENGTH bits each. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- fwd_valid, input, 1: a forward pre-activation vector is present on fwd_in.
- fwd_in, input, DATA_WIDTH x [0:LENGTH-1]: forward pre-activation vector.
- fwd_ready, output, 1: mask FIFO can accept an entry (count < DEPTH).
- grad_valid, input, 1: a gradient vector is present on grad_in.
- grad_in, input, DATA_WIDTH x [0:LENGTH-1]: incoming gradient vector.
- grad_ready, output, 1: a gradient vector will be accepted this cycle.
- grad_out, output, DATA_WIDTH x [0:LENGTH-1]: registered masked gradient vector.
- out_valid, output, 1: grad_out holds valid data.
- out_ready, input, 1: downstream accepts grad_out.
- count, output, $clog2(DEPTH+1): number of masks currently stored.
- overflow_err, output, 1: sticky; set when fwd_valid is high while fwd_ready is low.
- underflow_err, output, 1: sticky; set when grad_valid is high while count==0.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - count=0; read and write pointers=0.
  - out_valid=0; grad_out all zeros.
  - overflow_err=0; underflow_err=0.
  - Reset asserted mid-operation discards all stored masks and any pending output.
- Mask rule: mask[i]=1 iff fwd_in[i][DATA_WIDTH-1]==0 and fwd_in[i]!=0. Zero and negative values give mask 0, so the derivative at 0 is defined as 0.
- Push: when fwd_valid && fwd_ready, the mask is written at wr_ptr and wr_ptr advances, wrapping modulo DEPTH.
  - fwd_ready = (count < DEPTH). There is no push-while-full, even if a pop occurs in the same cycle.
- Pop:
  - grad_ready = (count != 0) && (!out_valid || out_ready).
  - On grad_valid && grad_ready: grad_out[i] <= mask[rd_ptr][i] ? grad_in[i] : 0; rd_ptr advances, wrapping modulo DEPTH; out_valid <= 1.
  - Latency is 1 cycle from grad handshake to out_valid.
- There is no bypass: a mask pushed in cycle N is poppable no earlier than cycle N+1. With count==0, grad_ready=0 even if fwd_valid is high.
- Ordering: strict FIFO. The k-th forward vector's mask is applied to the k-th gradient vector.
- Output stage:
  - out_valid and grad_out are held stable while out_valid && !out_ready.
  - If out_ready is high and there is no new pop, out_valid <= 0 and grad_out keeps its last value.
  - Back-to-back: out_ready high every cycle with grad_valid high gives one vector per cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Errors are sticky until reset and do not block operation. A rejected push or pop has no effect on the FIFO.
- Arithmetic: no arithmetic is performed. Elements are passed through or zeroed, with no width change.

Test Plan:
- Reset then idle -> count=0, out_valid=0, grad_out all 0, fwd_ready=1, grad_ready=0, error flags 0.
- Push fwd_in={5,-3,0,32767,-32768,1,...0}; next cycle grad_in all 0x0100 with out_ready=1 -> one cycle later grad_out={0x0100,0,0,0x0100,0,0x0100,0...}, out_valid=1, count returns to 0.
- Push 4 distinct masks (DEPTH=4), then a 5th fwd_valid -> fwd_ready=0, overflow_err=1, count stays 4. Popping 4 gradients returns masks in push order, and the pointers wrap correctly on the next push/pop cycle.
- Hold out_ready=0 after one pop while grad_valid stays high -> grad_ready=0, grad_out stable for 5 cycles, count unchanged. Raising out_ready -> the next pop occurs in that cycle.
- With count=2, push and pop in the same cycle -> count stays 2, and the output uses the oldest mask.
- grad_valid at count=0 -> underflow_err=1, no out_valid. Assert reset with count=3 and out_valid=1 -> all outputs are at reset values on the next cycle.

Source files
------------

// File: rtl/relu_backprop.sv
// ReLU backward gate: the forward pass records a strictly-positive mask per vector in a FIFO,
// and the backward pass pops masks in order and zeroes gradient elements into a registered output stage.
module relu_backprop #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fwd_valid,
    input  logic [DATA_WIDTH*LENGTH-1:0] fwd_in,
    output logic                         fwd_ready,
    input  logic                         grad_valid,
    input  logic [DATA_WIDTH*LENGTH-1:0] grad_in,
    output logic                         grad_ready,
    output logic [DATA_WIDTH*LENGTH-1:0] grad_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err,
    output logic                         underflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int VEC_W = DATA_WIDTH*LENGTH;

    logic [LENGTH-1:0] mask_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [VEC_W-1:0]  grad_out_q, grad_out_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [LENGTH-1:0] fwd_mask;
    logic [LENGTH-1:0] rd_mask;
    logic [VEC_W-1:0]  gated;
    logic              push;
    logic              pop;

    assign fwd_ready  = (count_q < CNT_W'(DEPTH));
    assign grad_ready = (count_q != '0) && (!out_valid_q || out_ready);
    assign push       = fwd_valid && fwd_ready;
    assign pop        = grad_valid && grad_ready;
    assign rd_mask    = mask_mem_q[rd_ptr_q];

    // Zero is not positive, so the derivative at 0 is taken as 0.
    always_comb begin
        fwd_mask = '0;
        for (int unsigned i = 0; i < LENGTH; i++) begin
            fwd_mask[i] = !fwd_in[i*DATA_WIDTH + DATA_WIDTH - 1] &&
                          (fwd_in[i*DATA_WIDTH +: DATA_WIDTH] != '0);
        end
    end

    always_comb begin
        gated = '0;
        for (int unsigned i = 0; i < LENGTH; i++) begin
            if (rd_mask[i]) begin
                gated[i*DATA_WIDTH +: DATA_WIDTH] = grad_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        grad_out_d  = grad_out_q;
        ovf_d       = ovf_q | (fwd_valid && !fwd_ready);
        unf_d       = unf_q | (grad_valid && (count_q == '0));

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new pop refills the stage; otherwise a consumed output just drops valid.
        if (pop) begin
            out_valid_d = 1'b1;
            grad_out_d  = gated;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            grad_out_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            grad_out_q  <= grad_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mask_mem_q[wr_ptr_q] <= fwd_mask;
        end
    end

    assign grad_out      = grad_out_q;
    assign out_valid     = out_valid_q;
    assign count         = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_relu_backprop.sv
// Bench for relu_backprop: hand-derived vector table, directed corner sequences and a random
// phase, all checked against a mask queue plus an expected-output scoreboard.
module tb_relu_backprop;
    localparam int DW    = 16;
    localparam int LEN   = 16;
    localparam int DEPTH = 4;
    localparam int W     = DW*LEN;
    localparam int CW    = $clog2(DEPTH+1);

    typedef logic [W-1:0]   vec_t;
    typedef logic [LEN-1:0] mask_t;
    typedef struct {
        vec_t fwd;
        vec_t grad;
        vec_t exp;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fwd_valid = 1'b0;
    vec_t          fwd_in = '0;
    logic          fwd_ready;
    logic          grad_valid = 1'b0;
    vec_t          grad_in = '0;
    logic          grad_ready;
    vec_t          grad_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] count;
    logic          overflow_err;
    logic          underflow_err;

    relu_backprop #(.DATA_WIDTH(DW), .LENGTH(LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
        .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
        .grad_out(grad_out), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_err    = 0;
    mask_t mq[$];
    vec_t  exp_q[$];
    vec_t  last_out;
    bit    m_ovf;
    bit    m_unf;
    rec_t  tbl[4];

    task automatic chk(input string name, input vec_t act, input vec_t req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t set_el(input vec_t v, input int i, input logic [DW-1:0] e);
        v[i*DW +: DW] = e;
        return v;
    endfunction

    function automatic vec_t fill(input logic [DW-1:0] e);
        vec_t v;
        for (int i = 0; i < LEN; i++) v[i*DW +: DW] = e;
        return v;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int i = 0; i < LEN; i++) begin
            if ($urandom_range(0, 3) == 0) v[i*DW +: DW] = '0;
            else                           v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    function automatic mask_t mask_of(input vec_t v);
        mask_t m;
        logic signed [DW-1:0] e;
        for (int i = 0; i < LEN; i++) begin
            e    = v[i*DW +: DW];
            m[i] = (e > 0);
        end
        return m;
    endfunction

    function automatic vec_t gate(input mask_t m, input vec_t g);
        vec_t o;
        for (int i = 0; i < LEN; i++) o[i*DW +: DW] = m[i] ? g[i*DW +: DW] : '0;
        return o;
    endfunction

    // One clock cycle: drive at posedge+1, check and advance the model at the negedge.
    task automatic step(input logic fv, input vec_t fin, input logic gv, input vec_t gin,
                        input logic ordy);
        bit    m_fr;
        bit    m_gr;
        mask_t m;
        fwd_valid  = fv;
        fwd_in     = fin;
        grad_valid = gv;
        grad_in    = gin;
        out_ready  = ordy;
        @(negedge clk);
        m_fr = (mq.size() < DEPTH);
        m_gr = (mq.size() != 0) && ((exp_q.size() == 0) || ordy);
        chk("fwd_ready", vec_t'(fwd_ready), vec_t'(m_fr));
        chk("grad_ready", vec_t'(grad_ready), vec_t'(m_gr));
        chk("count", vec_t'(count), vec_t'(mq.size()));
        chk("out_valid", vec_t'(out_valid), vec_t'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("grad_out", grad_out, exp_q[0]);
        else                   chk("grad_out_hold", grad_out, last_out);
        chk("overflow_err", vec_t'(overflow_err), vec_t'(m_ovf));
        chk("underflow_err", vec_t'(underflow_err), vec_t'(m_unf));
        if (exp_q.size() != 0 && ordy) last_out = exp_q.pop_front();
        if (fv && !m_fr) m_ovf = 1'b1;
        if (gv && mq.size() == 0) m_unf = 1'b1;
        if (gv && m_gr) begin
            m = mq.pop_front();
            exp_q.push_back(gate(m, gin));
        end
        if (fv && m_fr) mq.push_back(mask_of(fin));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Reset with both valids high and out_ready low, so reset must dominate everything.
    task automatic do_reset();
        reset      = 1'b1;
        fwd_valid  = 1'b1;
        fwd_in     = rvec();
        grad_valid = 1'b1;
        grad_in    = rvec();
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_count", vec_t'(count), '0);
        chk("rst_out_valid", vec_t'(out_valid), '0);
        chk("rst_grad_out", grad_out, '0);
        chk("rst_fwd_ready", vec_t'(fwd_ready), vec_t'(1));
        chk("rst_grad_ready", vec_t'(grad_ready), '0);
        chk("rst_overflow", vec_t'(overflow_err), '0);
        chk("rst_underflow", vec_t'(underflow_err), '0);
        reset      = 1'b0;
        fwd_valid  = 1'b0;
        grad_valid = 1'b0;
        out_ready  = 1'b1;
        fwd_in     = '0;
        grad_in    = '0;
        mq.delete();
        exp_q.delete();
        last_out = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: expected outputs derived by hand from the sign rule.
        tbl[0].fwd = '0;
        tbl[0].fwd = set_el(tbl[0].fwd, 0, 16'd5);
        tbl[0].fwd = set_el(tbl[0].fwd, 1, 16'hFFFD);
        tbl[0].fwd = set_el(tbl[0].fwd, 2, 16'h0000);
        tbl[0].fwd = set_el(tbl[0].fwd, 3, 16'h7FFF);
        tbl[0].fwd = set_el(tbl[0].fwd, 4, 16'h8000);
        tbl[0].fwd = set_el(tbl[0].fwd, 5, 16'h0001);
        tbl[0].grad = fill(16'h0100);
        tbl[0].exp  = '0;
        tbl[0].exp  = set_el(tbl[0].exp, 0, 16'h0100);
        tbl[0].exp  = set_el(tbl[0].exp, 3, 16'h0100);
        tbl[0].exp  = set_el(tbl[0].exp, 5, 16'h0100);

        tbl[1].fwd  = fill(16'h7FFF);
        tbl[2].fwd  = fill(16'h8000);
        tbl[2].grad = fill(16'hABCD);
        tbl[2].exp  = '0;
        tbl[3].fwd  = '0;
        tbl[3].exp  = '0;
        for (int i = 0; i < LEN; i++) begin
            tbl[1].grad = set_el(tbl[1].grad, i, DW'(i*273 + 1));
            tbl[1].exp  = set_el(tbl[1].exp, i, DW'(i*273 + 1));
            tbl[3].fwd  = set_el(tbl[3].fwd, i, (i % 2 == 0) ? 16'h0001 : 16'hFFFF);
            tbl[3].grad = set_el(tbl[3].grad, i, 16'hF000 | DW'(i));
            if (i % 2 == 0) tbl[3].exp = set_el(tbl[3].exp, i, 16'hF000 | DW'(i));
        end

        do_reset();
        idle(2);

        for (int r = 0; r < 4; r++) begin
            step(1'b1, tbl[r].fwd, 1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1, tbl[r].grad, 1'b1);
            chk("tbl_out_valid", vec_t'(out_valid), vec_t'(1));
            chk("tbl_grad_out", grad_out, tbl[r].exp);
        end
        idle(2);

        // Fill to DEPTH, attempt a fifth push, drain in order, then wrap the pointers.
        for (int k = 0; k < DEPTH; k++) step(1'b1, rvec(), 1'b0, '0, 1'b1);
        step(1'b1, rvec(), 1'b0, '0, 1'b1);
        chk("full_count", vec_t'(count), vec_t'(DEPTH));
        chk("full_overflow", vec_t'(overflow_err), vec_t'(1));
        for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b1, fill(16'hFFFF), 1'b1);
        step(1'b1, rvec(), 1'b0, '0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, rvec(), 1'b1, rvec(), 1'b1);
        step(1'b0, '0, 1'b1, rvec(), 1'b1);
        idle(2);

        // Backpressure: output held for 5 cycles, then the pop lands as out_ready rises.
        step(1'b1, rvec(), 1'b0, '0, 1'b1);
        step(1'b1, rvec(), 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, rvec(), 1'b0);
        begin
            vec_t g2;
            g2 = rvec();
            for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, g2, 1'b0);
            chk("bp_count", vec_t'(count), vec_t'(1));
            step(1'b0, '0, 1'b1, g2, 1'b1);
        end
        idle(2);

        // Simultaneous push and pop at count 2.
        step(1'b1, tbl[0].fwd, 1'b0, '0, 1'b1);
        step(1'b1, tbl[2].fwd, 1'b0, '0, 1'b1);
        step(1'b1, tbl[1].fwd, 1'b1, tbl[0].grad, 1'b1);
        chk("pp_count", vec_t'(count), vec_t'(2));
        chk("pp_oldest", grad_out, tbl[0].exp);
        step(1'b0, '0, 1'b1, rvec(), 1'b1);
        step(1'b0, '0, 1'b1, rvec(), 1'b1);
        idle(2);

        // Underflow: gradient offered with an empty FIFO.
        step(1'b0, '0, 1'b1, rvec(), 1'b1);
        chk("uf_out_valid", vec_t'(out_valid), '0);
        idle(1);
        chk("uf_flag", vec_t'(underflow_err), vec_t'(1));

        // Reset with count 3 and a pending output.
        for (int k = 0; k < DEPTH; k++) step(1'b1, rvec(), 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, rvec(), 1'b0);
        chk("pre_rst_count", vec_t'(count), vec_t'(3));
        chk("pre_rst_valid", vec_t'(out_valid), vec_t'(1));
        do_reset();
        idle(1);

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), rvec(), 1'($urandom_range(0, 1)), rvec(),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
